// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a four byte-lane data memory between the pipeline
// memory stage (port A, priority) and a loader/debug requester (port B).
// A starvation counter force-grants B after MAX_WAIT blocked cycles.
// Read responses come back one cycle after the grant to whichever port
// owned the read. Loads are size-aligned and extended.
//
// Handshake: port A is a request/stall interface. A request with a_req high
// and a_stall low is consumed in that cycle. Port B is valid/ready: a request
// transfers on a rising edge where b_valid and b_ready are both high, and
// b_ready is never asserted without b_valid. Read and error responses
// (*_rvalid) are single-cycle pulses that cannot be back-pressured.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 13
) (
  input  logic              clk,
  input  logic              rst,
  // port A: pipeline memory stage
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_unsigned,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_stall,
  output logic              a_misalign,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  // port B: loader / debug
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_unsigned,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_rvalid,
  output logic              b_err,
  output logic [31:0]       b_rdata,
  // memory lanes
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wren,
  output logic              mem_rden,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

  // Alignment rule: byte anywhere, half on even offsets, word on offset 0,
  // reserved size never aligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   isMisaligned = 1'b0;
      2'b01:   isMisaligned = off[0];
      2'b10:   isMisaligned = (off != 2'b00);
      default: isMisaligned = 1'b1;
    endcase
  endfunction

  // Byte lanes touched by an aligned access of the given size and offset.
  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   laneMask = 4'b0001 << off;
      2'b01:   laneMask = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   laneMask = 4'b1111;
      default: laneMask = 4'b0000;
    endcase
  endfunction

  logic        aMisCond;
  logic        bMisCond;
  logic        grantA;
  logic        grantB;
  logic [3:0]  starve;
  logic [3:0]  starveNext;

  logic        selWe;
  logic [1:0]  selSize;
  logic        selUns;
  logic [31:0] selAddr;
  logic [31:0] selWdata;
  logic        memActive;

  owner_t      rdOwner;
  owner_t      rdOwnerNext;
  logic [1:0]  rdOff;
  logic [1:0]  rdSize;
  logic        rdUns;
  logic        rdErr;
  logic [31:0] loadData;

  // Upper address bits lie outside the memory and are intentionally ignored.
  logic        unusedAddrBits;
  assign unusedAddrBits = ^{a_addr[31:ADDR_W+2], b_addr[31:ADDR_W+2]};

  // Grant decision: A wins unless it is idle, misaligned, or B has starved.
  always_comb begin
    aMisCond   = isMisaligned(a_size, a_addr[1:0]);
    bMisCond   = isMisaligned(b_size, b_addr[1:0]);
    grantB     = b_valid & (~a_req | aMisCond | (starve == STARVE_MAX));
    grantA     = a_req & ~aMisCond & ~grantB;
    a_stall    = a_req & ~aMisCond & grantB;
    a_misalign = a_req & aMisCond;
    b_ready    = grantB;
  end

  // Starvation counter: counts blocked B cycles, saturating at MAX_WAIT.
  always_comb begin
    starveNext = starve;
    if (grantB || !b_valid) begin
      starveNext = 4'd0;
    end else if (starve != STARVE_MAX) begin
      starveNext = starve + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= 4'd0;
    end else begin
      starve <= starveNext;
    end
  end

  // Request mux: select the granted port; a misaligned B grant touches nothing.
  always_comb begin
    selWe     = 1'b0;
    selSize   = 2'b00;
    selUns    = 1'b0;
    selAddr   = 32'd0;
    selWdata  = 32'd0;
    memActive = 1'b0;
    if (grantA) begin
      selWe     = a_we;
      selSize   = a_size;
      selUns    = a_unsigned;
      selAddr   = a_addr;
      selWdata  = a_wdata;
      memActive = 1'b1;
    end else if (grantB) begin
      selWe     = b_we;
      selSize   = b_size;
      selUns    = b_unsigned;
      selAddr   = b_addr;
      selWdata  = b_wdata;
      memActive = ~bMisCond;
    end
  end

  // Memory drive: word address, lane enables and lane-replicated store data.
  always_comb begin
    mem_addr  = '0;
    mem_wren  = 4'b0000;
    mem_rden  = 1'b0;
    mem_wdata = 32'd0;
    if (memActive) begin
      mem_addr = selAddr[ADDR_W+1:2];
      mem_rden = ~selWe;
      if (selWe) begin
        mem_wren = laneMask(selSize, selAddr[1:0]);
      end
      case (selSize)
        2'b00:   mem_wdata = {4{selWdata[7:0]}};
        2'b01:   mem_wdata = {2{selWdata[15:0]}};
        default: mem_wdata = selWdata;
      endcase
    end
  end

  // Owner of next cycle's response: aligned reads, plus any misaligned B
  // access, which is answered with an error instead of data.
  always_comb begin
    rdOwnerNext = OWN_NONE;
    if (grantA && !a_we) begin
      rdOwnerNext = OWN_A;
    end else if (grantB && (!b_we || bMisCond)) begin
      rdOwnerNext = OWN_B;
    end
  end

  // Read tracking registers, reloaded every cycle; reset drops any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdOwner <= OWN_NONE;
      rdOff   <= 2'b00;
      rdSize  <= 2'b00;
      rdUns   <= 1'b0;
      rdErr   <= 1'b0;
    end else begin
      rdOwner <= rdOwnerNext;
      rdOff   <= selAddr[1:0];
      rdSize  <= selSize;
      rdUns   <= selUns;
      rdErr   <= grantB & bMisCond;
    end
  end

  // Load extraction: pick byte/half by offset, then sign- or zero-extend.
  always_comb begin
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel = mem_rdata[8*rdOff +: 8];
    halfSel = rdOff[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (rdSize)
      2'b00:   loadData = {{24{~rdUns & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{~rdUns & halfSel[15]}}, halfSel};
      default: loadData = mem_rdata;
    endcase
  end

  // Response steering: only the owning port sees data; errors carry zero data.
  always_comb begin
    a_rvalid = (rdOwner == OWN_A);
    b_rvalid = (rdOwner == OWN_B);
    b_err    = (rdOwner == OWN_B) & rdErr;
    a_rdata  = (rdOwner == OWN_A) ? loadData : 32'd0;
    b_rdata  = ((rdOwner == OWN_B) && !rdErr) ? loadData : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural lane memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req, a_we, a_unsigned;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic        a_stall, a_misalign, a_rvalid;
  logic [31:0] a_rdata;
  logic        b_valid, b_ready, b_we, b_unsigned;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata;
  logic        b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic [12:0] mem_addr;
  logic [3:0]  mem_wren;
  logic        mem_rden;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] memArr [0:8191];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.MAX_WAIT(4), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_unsigned(a_unsigned),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_stall(a_stall), .a_misalign(a_misalign),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_size(b_size),
    .b_unsigned(b_unsigned), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: per-lane writes, one-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wren[i]) memArr[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    if (mem_rden) mem_rdata <= memArr[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_size = 2'b00; a_unsigned = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_size = 2'b00; b_unsigned = 0; b_addr = 0; b_wdata = 0;
  endtask

  task automatic drive_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    a_req = 1; a_we = we; a_size = size; a_unsigned = uns; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    b_valid = 1; b_we = we; b_size = size; b_unsigned = uns; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #12;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL reset_a_rvalid: got %b expected 0", a_rvalid); end
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL reset_b_rvalid: got %b expected 0", b_rvalid); end
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL reset_b_err: got %b expected 0", b_err); end
    checks++; if (mem_wren !== 4'b0000) begin errors++; $display("FAIL reset_mem_wren: got %b expected 0000", mem_wren); end
    checks++; if (mem_rden !== 1'b0) begin errors++; $display("FAIL reset_mem_rden: got %b expected 0", mem_rden); end
    checks++; if ({a_stall, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_stall_ready: got %b expected 00", {a_stall, b_ready}); end
    @(negedge clk);
    rst = 1;
    step();
  endtask

  task automatic test_word_read();
    drive_a(0, 2'b10, 0, 32'h10, 0);
    #1;
    checks++; if (mem_addr !== 13'd4) begin errors++; $display("FAIL word_mem_addr: got %0d expected 4", mem_addr); end
    checks++; if (mem_rden !== 1'b1) begin errors++; $display("FAIL word_mem_rden: got %b expected 1", mem_rden); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL word_a_stall: got %b expected 0", a_stall); end
    step();
    idle_inputs();
    #1;
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL word_a_rvalid: got %b expected 1", a_rvalid); end
    checks++; if (a_rdata !== 32'h8000_00F0) begin errors++; $display("FAIL word_a_rdata: got %h expected 800000f0", a_rdata); end
    checks++; if ({b_rvalid, b_rdata} !== 33'd0) begin errors++; $display("FAIL word_b_quiet: got %b/%h expected 0/0", b_rvalid, b_rdata); end
    step();
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL word_a_rvalid_one_cycle: got %b expected 0", a_rvalid); end
  endtask

  task automatic test_byte_store_load();
    drive_a(1, 2'b00, 0, 32'h13, 32'h1234_56AB);
    #1;
    checks++; if (mem_wren !== 4'b1000) begin errors++; $display("FAIL sb_mem_wren: got %b expected 1000", mem_wren); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_mem_wdata: got %h expected abababab", mem_wdata); end
    checks++; if (mem_rden !== 1'b0) begin errors++; $display("FAIL sb_mem_rden: got %b expected 0", mem_rden); end
    step();
    drive_a(0, 2'b00, 0, 32'h13, 0);
    #1;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL sb_no_response: got %b expected 0", a_rvalid); end
    step();
    drive_a(0, 2'b00, 1, 32'h13, 0);
    #1;
    checks++; if (a_rdata !== 32'hFFFF_FFAB) begin errors++; $display("FAIL lb_a_rdata: got %h expected ffffffab", a_rdata); end
    step();
    idle_inputs();
    #1;
    checks++; if (a_rdata !== 32'h0000_00AB) begin errors++; $display("FAIL lbu_a_rdata: got %h expected 000000ab", a_rdata); end
    step();
  endtask

  task automatic test_b_half();
    drive_b(0, 2'b01, 0, 32'h22, 0);
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL bh_b_ready: got %b expected 1", b_ready); end
    checks++; if (mem_addr !== 13'd8) begin errors++; $display("FAIL bh_mem_addr: got %0d expected 8", mem_addr); end
    step();
    drive_b(1, 2'b01, 0, 32'h26, 32'h0000_BEEF);
    #1;
    checks++; if ({b_rvalid, b_err} !== 2'b10) begin errors++; $display("FAIL bh_b_rvalid_err: got %b expected 10", {b_rvalid, b_err}); end
    checks++; if (b_rdata !== 32'hFFFF_8765) begin errors++; $display("FAIL bh_b_rdata: got %h expected ffff8765", b_rdata); end
    checks++; if (a_rdata !== 32'd0) begin errors++; $display("FAIL bh_a_rdata: got %h expected 0", a_rdata); end
    checks++; if (mem_wren !== 4'b1100) begin errors++; $display("FAIL sh_mem_wren: got %b expected 1100", mem_wren); end
    checks++; if (mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_mem_wdata: got %h expected beefbeef", mem_wdata); end
    step();
    idle_inputs();
    #1;
    checks++; if (b_rvalid !== 1'b0) begin errors++; $display("FAIL sh_no_response: got %b expected 0", b_rvalid); end
    step();
  endtask

  task automatic test_misalign();
    drive_a(0, 2'b10, 0, 32'h02, 0);
    drive_b(1, 2'b10, 0, 32'h01, 32'hDEAD_BEEF);
    #1;
    checks++; if (a_misalign !== 1'b1) begin errors++; $display("FAIL mis_a_misalign: got %b expected 1", a_misalign); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL mis_a_stall: got %b expected 0", a_stall); end
    checks++; if ({mem_rden, mem_wren} !== 5'b0) begin errors++; $display("FAIL mis_mem_idle: got %b expected 00000", {mem_rden, mem_wren}); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL mis_b_ready: got %b expected 1", b_ready); end
    step();
    idle_inputs();
    #1;
    checks++; if ({b_rvalid, b_err} !== 2'b11) begin errors++; $display("FAIL mis_b_err: got %b expected 11", {b_rvalid, b_err}); end
    checks++; if (b_rdata !== 32'd0) begin errors++; $display("FAIL mis_b_rdata: got %h expected 0", b_rdata); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL mis_a_rvalid: got %b expected 0", a_rvalid); end
    checks++; if (memArr[0] !== 32'h1122_3344) begin errors++; $display("FAIL mis_mem_unchanged: got %h expected 11223344", memArr[0]); end
    step();
  endtask

  task automatic test_starvation();
    drive_a(0, 2'b10, 0, 32'h10, 0);
    drive_b(0, 2'b10, 0, 32'h20, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (b_ready !== (c == 4)) begin errors++; $display("FAIL starve_b_ready_c%0d: got %b expected %b", c, b_ready, (c == 4)); end
      checks++; if (a_stall !== (c == 4)) begin errors++; $display("FAIL starve_a_stall_c%0d: got %b expected %b", c, a_stall, (c == 4)); end
      step();
    end
    checks++; if ({b_ready, a_stall} !== 2'b00) begin errors++; $display("FAIL starve_counter_cleared: got %b expected 00", {b_ready, a_stall}); end
    checks++; if (b_rvalid !== 1'b1) begin errors++; $display("FAIL starve_b_rvalid: got %b expected 1", b_rvalid); end
    checks++; if (b_rdata !== 32'h8765_4321) begin errors++; $display("FAIL starve_b_rdata: got %h expected 87654321", b_rdata); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    drive_a(0, 2'b10, 0, 32'h10, 0);
    step();
    idle_inputs();
    drive_b(0, 2'b00, 1, 32'h21, 0);
    #1;
    checks++; if (a_rdata !== 32'hAB00_00F0) begin errors++; $display("FAIL b2b_a_word: got %h expected ab0000f0", a_rdata); end
    step();
    idle_inputs();
    drive_a(0, 2'b01, 1, 32'h12, 0);
    #1;
    checks++; if ({a_rvalid, b_rvalid} !== 2'b01) begin errors++; $display("FAIL b2b_owner_b: got %b expected 01", {a_rvalid, b_rvalid}); end
    checks++; if (b_rdata !== 32'h0000_0043) begin errors++; $display("FAIL b2b_b_byte: got %h expected 00000043", b_rdata); end
    step();
    idle_inputs();
    #1;
    checks++; if ({a_rvalid, b_rvalid} !== 2'b10) begin errors++; $display("FAIL b2b_owner_a: got %b expected 10", {a_rvalid, b_rvalid}); end
    checks++; if (a_rdata !== 32'h0000_AB00) begin errors++; $display("FAIL b2b_a_half: got %h expected 0000ab00", a_rdata); end
    step();
  endtask

  task automatic test_reset_mid_read();
    drive_a(0, 2'b10, 0, 32'h10, 0);
    step();
    idle_inputs();
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL rst_pending_before: got %b expected 1", a_rvalid); end
    rst = 0;
    #1;
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_async_drop: got %b expected 0", a_rvalid); end
    step();
    rst = 1;
    step();
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_after_release1: got %b expected 0", a_rvalid); end
    drive_a(0, 2'b10, 0, 32'h10, 0);
    #1;
    rst = 0;
    step();
    idle_inputs();
    rst = 1;
    step();
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_after_release2: got %b expected 0", a_rvalid); end
  endtask

  initial begin
    memArr[0] = 32'h1122_3344;
    memArr[4] = 32'h8000_00F0;
    memArr[8] = 32'h8765_4321;
    mem_rdata = 32'd0;
    test_reset();
    test_word_read();
    test_byte_store_load();
    test_b_half();
    test_misalign();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
